add_acc_5b: RTL and testbench
=============================

Name: add_acc_5b

Overview:
Sequential operand accumulator that sits directly upstream-to-downstream around the 5-bit ripple full adder (fa_5b).
- Accepts a stream of 5-bit operands over a valid/ready handshake.
- Adds each operand into a running 5-bit sum through one fa_5b instance.
- Reports the final sum and a sticky carry-out (overflow) flag once a programmed number of operands has been consumed.
- Used wherever multi-operand 5-bit sums are needed without a tree of adders.

Parameters:
WIDTH, 5, operand/sum width; fixed at 5 for fa_5b compatibility.
CNT_W, 4, width of operand-count field; max 15 operands per job.

Ports:
clk        input   1        rising-edge clock
rst_n      input   1        asynchronous active-low reset
start      input   1        job start pulse; sampled only in IDLE
len        input   CNT_W    number of operands for the job; sampled with start
in_valid   input   1        operand valid
in_ready   output  1        block can accept an operand this cycle
in_data    input   WIDTH    operand
out_valid  output  1        result valid
out_ready  input   1        consumer accepts result
sum        output  WIDTH    accumulated sum, modulo 2^WIDTH (see SAT_EN)
ovf        output  1        sticky: any addition in the job produced cout=1
busy       output  1        high in ACC or DONE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; acc=0, cnt=0, ovf=0.
  - in_ready=0, out_valid=0, busy=0, sum=0.
  - Applies immediately, including mid-job; a partial job is discarded and no result is emitted.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 and len!=0: acc<=0, ovf<=0, cnt<=len, next ACC.
  - start=1 and len==0: acc<=0, ovf<=0, next DONE; zero-length job gives sum=0, ovf=0.
- ACC:
  - in_ready=1.
  - A beat transfers when in_valid&in_ready.
  - On a transfer: {cout,s} = fa_5b(acc, in_data, cin=0); acc<=s; ovf<=ovf|cout; cnt<=cnt-1.
  - Transfer with cnt==1: next DONE.
  - No transfer: state, acc, cnt and ovf hold.
- DONE:
  - out_valid=1; sum=acc and ovf are stable while out_valid is high.
  - out_ready=1: next IDLE.
  - out_valid can be high when out_ready is low for any number of cycles; nothing changes.
- Latency:
  - out_valid rises the cycle after the last operand transfer.
  - For a zero-length job, out_valid rises the cycle after start.
  - At one beat per cycle, throughput is len+2 cycles per job (including the IDLE return).
- start while not in IDLE is ignored; len is not re-sampled.
- in_data is ignored when in_ready=0.
- sum drives acc in every state; it is only meaningful while out_valid=1.
- Arithmetic wraps modulo 32 and cout is captured only into ovf. This default changes under SAT_EN.

Optional Feature:
Macro ADD_ACC_SAT_EN.
- Defined: any add with cout=1 sets acc<=5'h1F, and acc remains 5'h1F for the rest of the job, whatever later operands are. ovf is still set.
- Undefined: wrap-around arithmetic as in Behaviour; no saturation logic is synthesized.

Decomposition:
- Shared package add_acc_pkg holds:
  - WIDTH/CNT_W defaults.
  - State enum (IDLE=2'd0, ACC=2'd1, DONE=2'd2).
  - Constant SAT_VAL=5'h1F.
- One sub-module: the existing fa_5b (a, b, cin -> s, cout), instantiated once combinationally on acc/in_data. The FSM, counter and registers stay in add_acc_5b.

Test Plan:
- len=3; operands 3,4,5 back-to-back; out_ready=1 -> out_valid high the cycle after the 3rd beat; sum=12 (01100), ovf=0; busy low the cycle after.
- len=2; operands 10100, 10010 -> sum=00110, ovf=1. With ADD_ACC_SAT_EN defined: sum=11111, ovf=1.
- len=0 with start -> out_valid next cycle; sum=0, ovf=0; in_ready never asserted.
- len=2; in_valid toggled 1,0,0,1 with operands 6,6; out_ready held 0 for 5 cycles -> sum=12 held stable and out_valid high for all 5 cycles; returns to IDLE only on out_ready=1. A start pulse during DONE is ignored.
- len=4; rst_n pulsed low after the 2nd beat -> immediately in_ready=0, out_valid=0, sum=0, ovf=0. A new job len=1 with operand 7 then yields sum=7, ovf=0.

Source files
------------

// File: rtl/add_acc_pkg.sv
// -----------------------------------------------------------------------------
// add_acc_pkg
// Shared definitions for the 5-bit operand accumulator.
//   DEF_WIDTH  : default operand/sum width (must stay 5 to match fa_5b)
//   DEF_CNT_W  : default operand-count width (up to 15 operands per job)
//   state_t    : accumulator FSM states
//   SAT_VAL    : value the accumulator clamps to when ADD_ACC_SAT_EN is defined
// -----------------------------------------------------------------------------
package add_acc_pkg;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DEF_WIDTH-1:0] SAT_VAL = 5'h1F;

endpackage : add_acc_pkg

// File: rtl/fa_5b.sv
// -----------------------------------------------------------------------------
// fa_5b
// Purely combinational 5-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b  : 5-bit addends
//   cin   : carry in
//   s     : 5-bit sum
//   cout  : carry out of the top bit
// -----------------------------------------------------------------------------
module fa_5b
    import add_acc_pkg::*;
(
    input  logic [DEF_WIDTH-1:0] a,
    input  logic [DEF_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [DEF_WIDTH-1:0] s,
    output logic                 cout
);

    logic [DEF_WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DEF_WIDTH; i++) begin : g_bit
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[DEF_WIDTH];

endmodule : fa_5b

// File: rtl/add_acc_5b.sv
// -----------------------------------------------------------------------------
// add_acc_5b
// Sequential accumulator: sums a programmed number of 5-bit operands received
// over a valid/ready handshake using a single fa_5b, then presents the sum and
// a sticky overflow flag over a valid/ready result handshake.
// Ports:
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   start, len           : job start pulse and operand count (sampled in IDLE)
//   in_valid, in_ready   : operand handshake; in_data is the operand
//   out_valid, out_ready : result handshake; sum/ovf are the result
//   busy                 : high while a job is accumulating or waiting in DONE
// Build option:
//   ADD_ACC_SAT_EN       : when defined, an add that carries out clamps the
//                          accumulator to SAT_VAL for the rest of the job.
// -----------------------------------------------------------------------------
module add_acc_5b
    import add_acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic             busy
);

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ovf_q,       ovf_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;

    logic [WIDTH-1:0] add_s;
    logic             add_cout;
    logic             xfer;

    fa_5b u_fa (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    // in_ready_q is high exactly when the FSM sits in ACC.
    assign xfer = in_valid & in_ready_q;

    always_comb begin
        // NOTE: every variable gets a hold-value default first so no path through
        // the case statement leaves it unassigned, which would infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = len;
                    state_d = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (xfer) begin
`ifdef ADD_ACC_SAT_EN
                    // Once clamped, every later non-zero add also carries out,
                    // so the accumulator stays at SAT_VAL for the rest of the job.
                    acc_d = add_cout ? SAT_VAL : add_s;
`else
                    acc_d = add_s;
`endif
                    ovf_d = ovf_q | add_cout;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are decoded from the next state so they come straight
        // off flops in the cycle the FSM enters each state.
        in_ready_d  = (state_d == ACC);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all control and datapath flops are reset here; there is no memory
        // array, so nothing is left to power up undefined.
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = acc_q;
    assign ovf       = ovf_q;

endmodule : add_acc_5b

// File: tb/tb_add_acc_5b.sv
// -----------------------------------------------------------------------------
// tb_add_acc_5b
// Self-checking bench for add_acc_5b. Expected results come from a plain
// integer model of a multi-operand sum (wrap or clamp at 31, sticky carry).
// -----------------------------------------------------------------------------
module tb_add_acc_5b;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] sum;
    logic       ovf;
    logic       busy;

    int vectors = 0;
    int errs    = 0;

    add_acc_5b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: integer running sum; any partial sum above 31 sets ovf.
    function automatic void model(input int n, input logic [4:0] ops [16],
                                  output logic [4:0] s, output logic o);
        int a;
        a = 0;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = a + int'(ops[i]);
            if (a > 31) begin
                o = 1'b1;
`ifdef ADD_ACC_SAT_EN
                a = 31;
`else
                a = a - 32;
`endif
            end
        end
        s = 5'(a);
    endfunction

    // Run one job from IDLE through the result handshake back to IDLE.
    task automatic do_job(input string name, input int n, input logic [4:0] ops [16],
                          input bit use_pat, input logic [31:0] vpat,
                          input int stall, input bit poke_start);
        logic [4:0] exp_s;
        logic       exp_o;
        int         beat;
        int         cyc;
        bit         v;

        model(n, ops, exp_s, exp_o);

        start = 1'b1;
        len   = 4'(n);
        step();
        start = 1'b0;
        len   = 4'($urandom_range(0, 15));

        vectors++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL %s busy_after_start got %b want 1", name, busy);
        end

        beat = 0;
        cyc  = 0;
        while (beat < n) begin
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errs++;
                $display("FAIL %s acc_flags in_ready=%b out_valid=%b want 1/0 beat %0d",
                         name, in_ready, out_valid, beat);
            end
            v = use_pat ? vpat[cyc % 32] : ($urandom_range(0, 3) != 0);
            in_valid = v;
            in_data  = v ? ops[beat] : 5'($urandom);
            step();
            if (v) beat++;
            cyc++;
            if (cyc > 200) begin
                errs++;
                $display("FAIL %s beat_timeout got %0d beats want %0d", name, beat, n);
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = 5'($urandom);

        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== exp_s || ovf !== exp_o) begin
            errs++;
            $display("FAIL %s result out_valid=%b in_ready=%b sum=%b ovf=%b want 1/0 sum=%b ovf=%b",
                     name, out_valid, in_ready, sum, ovf, exp_s, exp_o);
        end

        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            in_data  = 5'($urandom);
            start    = poke_start && (i == 1);
            len      = 4'd5;
            step();
            vectors++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || sum !== exp_s || ovf !== exp_o) begin
                errs++;
                $display("FAIL %s stall_%0d out_valid=%b busy=%b sum=%b ovf=%b want 1/1 sum=%b ovf=%b",
                         name, i, out_valid, busy, sum, ovf, exp_s, exp_o);
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL %s idle_return out_valid=%b busy=%b in_ready=%b want 0/0/0",
                     name, out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_data   = 5'd0;
        out_ready = 1'b0;
        #3;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 5'd0 || ovf !== 1'b0) begin
            errs++;
            $display("FAIL reset outputs in_ready=%b out_valid=%b busy=%b sum=%b ovf=%b want all 0",
                     in_ready, out_valid, busy, sum, ovf);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle busy=%b out_valid=%b want 0/0", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [4:0] ops [16];
        foreach (ops[i]) ops[i] = 5'd0;
        ops[0] = 5'd3; ops[1] = 5'd4; ops[2] = 5'd5;
        do_job("basic", 3, ops, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    endtask

    task automatic test_overflow();
        logic [4:0] ops [16];
        foreach (ops[i]) ops[i] = 5'd0;
        ops[0] = 5'b10100; ops[1] = 5'b10010;
        do_job("overflow", 2, ops, 1'b1, 32'hFFFF_FFFF, 1, 1'b0);
    endtask

    task automatic test_zero_len();
        logic [4:0] ops [16];
        foreach (ops[i]) ops[i] = 5'($urandom);
        do_job("zero_len", 0, ops, 1'b1, 32'hFFFF_FFFF, 3, 1'b0);
    endtask

    task automatic test_stall();
        logic [4:0] ops [16];
        foreach (ops[i]) ops[i] = 5'd0;
        ops[0] = 5'd6; ops[1] = 5'd6;
        do_job("stall", 2, ops, 1'b1, 32'b1001, 5, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [16];
        for (int j = 0; j < 3; j++) begin
            foreach (ops[i]) ops[i] = 5'($urandom);
            do_job("back_to_back", 15, ops, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
        end
    endtask

    task automatic test_midjob_reset();
        logic [4:0] ops [16];
        start = 1'b1;
        len   = 4'd4;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 5'd9;
        step();
        in_data  = 5'd11;
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || sum !== 5'd0 || ovf !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL midjob_reset in_ready=%b out_valid=%b sum=%b ovf=%b busy=%b want all 0",
                     in_ready, out_valid, sum, ovf, busy);
        end
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL midjob_discard out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
        foreach (ops[i]) ops[i] = 5'd0;
        ops[0] = 5'd7;
        do_job("after_reset", 1, ops, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0] ops [16];
        for (int j = 0; j < 25; j++) begin
            foreach (ops[i]) ops[i] = 5'($urandom);
            do_job("random", int'($urandom_range(0, 15)), ops, 1'b0, 32'h0,
                   int'($urandom_range(0, 4)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_zero_len();
        test_stall();
        test_back_to_back();
        test_midjob_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule : tb_add_acc_5b
